// File: rtl/fetch_queue_pkg.sv
// Shared constants for the fetch queue: default field widths and the reset/idle instruction.
package fetch_queue_pkg;

   localparam int unsigned INST_ADDR_WIDTH = 32;
   localparam int unsigned REG_DATA_WIDTH  = 32;
   localparam logic [31:0] INST_NOP        = 32'h0000_0013;

endpackage : fetch_queue_pkg

// File: rtl/fetch_queue_mem.sv
// DEPTH x {pc, inst} register array: one write port, one asynchronous read port,
// asynchronous active-low reset of every entry to pc=0 / NOP.
module fetch_queue_mem
   import fetch_queue_pkg::*;
#(
   parameter int unsigned ADDR_W = INST_ADDR_WIDTH,
   parameter int unsigned INST_W = REG_DATA_WIDTH,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              we,
   input  logic [PTR_W-1:0]  waddr,
   input  logic [ADDR_W-1:0] wpc,
   input  logic [INST_W-1:0] winst,
   input  logic [PTR_W-1:0]  raddr,
   output logic [ADDR_W-1:0] rpc,
   output logic [INST_W-1:0] rinst
);

   logic [ADDR_W-1:0] pc_q   [DEPTH];
   logic [INST_W-1:0] inst_q [DEPTH];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            pc_q[i]   <= '0;
            inst_q[i] <= INST_W'(INST_NOP);
         end
      end else if (we) begin
         pc_q[waddr]   <= wpc;
         inst_q[waddr] <= winst;
      end
   end

   always_comb begin
      rpc   = pc_q[raddr];
      rinst = inst_q[raddr];
   end

endmodule : fetch_queue_mem

// File: rtl/fetch_queue.sv
// Fetch-to-decode FIFO of {pc, inst} with valid/ready on both sides and synchronous flush.
// Optional zero-latency empty-queue bypass: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int unsigned ADDR_W = INST_ADDR_WIDTH,
   parameter int unsigned INST_W = REG_DATA_WIDTH,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [ADDR_W-1:0]          in_pc,
   input  logic [INST_W-1:0]          in_inst,
   input  logic                       flush,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [ADDR_W-1:0]          out_pc,
   output logic [INST_W-1:0]          out_inst,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [ADDR_W-1:0] mem_pc;
   logic [INST_W-1:0] mem_inst;
   logic              empty;
   logic              wr_en;
   logic              rd_en;
`ifdef FETCH_QUEUE_BYPASS_EN
   logic              bypass;
`endif

   always_comb begin
      empty    = (count == '0);
      in_ready = (count != CNT_W'(DEPTH));
      rd_en    = !empty && out_ready;
`ifdef FETCH_QUEUE_BYPASS_EN
      // An entry taken straight through to decode never touches storage or count.
      bypass    = empty && in_valid && !flush;
      out_valid = !empty || bypass;
      wr_en     = in_valid && in_ready && !(bypass && out_ready);
      if (!empty) begin
         out_pc   = mem_pc;
         out_inst = mem_inst;
      end else if (bypass) begin
         out_pc   = in_pc;
         out_inst = in_inst;
      end else begin
         out_pc   = '0;
         out_inst = INST_W'(INST_NOP);
      end
`else
      out_valid = !empty;
      wr_en     = in_valid && in_ready;
      out_pc    = empty ? '0 : mem_pc;
      out_inst  = empty ? INST_W'(INST_NOP) : mem_inst;
`endif
   end

   fetch_queue_mem #(
      .ADDR_W (ADDR_W),
      .INST_W (INST_W),
      .DEPTH  (DEPTH),
      .PTR_W  (PTR_W)
   ) u_mem (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (wr_en && !flush),
      .waddr   (wr_ptr),
      .wpc     (in_pc),
      .winst   (in_inst),
      .raddr   (rd_ptr),
      .rpc     (mem_pc),
      .rinst   (mem_inst)
   );

   // Flush only rewinds the pointers; stale storage is masked by count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
         if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({wr_en, rd_en})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_fetch_queue;

   localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_QUEUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [31:0] in_inst;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic [2:0]  count;

   fetch_queue #(
      .ADDR_W (32),
      .INST_W (32),
      .DEPTH  (4)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pc     (in_pc),
      .in_inst   (in_inst),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pc    (out_pc),
      .out_inst  (out_inst),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic        v;
      logic [31:0] pc;
      logic        ordy;
      logic        ev;
      logic        er;
      logic [31:0] epc;
      logic [31:0] einst;
      logic [2:0]  ecnt;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } entry_t;

   vec_t   tbl [10];
   entry_t model_q [$];

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return pc ^ 32'hA5A5_0000;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic chk_all(input string nm, input logic ev, input logic er,
                          input logic [31:0] epc, input logic [31:0] einst,
                          input logic [2:0] ecnt);
      chk({nm, ".out_valid"}, 32'(out_valid), 32'(ev));
      chk({nm, ".in_ready"},  32'(in_ready),  32'(er));
      chk({nm, ".out_pc"},    out_pc,         epc);
      chk({nm, ".out_inst"},  out_inst,       einst);
      chk({nm, ".count"},     32'(count),     32'(ecnt));
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic fl, input logic ordy);
      in_valid  = v;
      in_pc     = pc;
      in_inst   = inst_of(pc);
      flush     = fl;
      out_ready = ordy;
   endtask

   initial begin
      logic [31:0] epc;
      logic        ev;
      logic [2:0]  ec;

      reset_n = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b0);

      // Fill to full, refuse a 5th entry, then drain in order.
      tbl[0] = '{1'b1, 32'h00, 1'b0, BYP,  1'b1, 32'h00, BYP ? inst_of(32'h0) : NOP, 3'd0};
      tbl[1] = '{1'b1, 32'h04, 1'b0, 1'b1, 1'b1, 32'h00, inst_of(32'h00), 3'd1};
      tbl[2] = '{1'b1, 32'h08, 1'b0, 1'b1, 1'b1, 32'h00, inst_of(32'h00), 3'd2};
      tbl[3] = '{1'b1, 32'h0C, 1'b0, 1'b1, 1'b1, 32'h00, inst_of(32'h00), 3'd3};
      tbl[4] = '{1'b1, 32'h10, 1'b0, 1'b1, 1'b0, 32'h00, inst_of(32'h00), 3'd4};
      tbl[5] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 32'h00, inst_of(32'h00), 3'd4};
      tbl[6] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'h04, inst_of(32'h04), 3'd3};
      tbl[7] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'h08, inst_of(32'h08), 3'd2};
      tbl[8] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'h0C, inst_of(32'h0C), 3'd1};
      tbl[9] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 32'h00, NOP,             3'd0};

      repeat (2) @(negedge clk);
      chk_all("in_reset", 1'b0, 1'b1, 32'h0, NOP, 3'd0);
      reset_n = 1'b1;
      #1 chk_all("idle", 1'b0, 1'b1, 32'h0, NOP, 3'd0);
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].v, tbl[i].pc, 1'b0, tbl[i].ordy);
         #1 chk_all($sformatf("fill%0d", i), tbl[i].ev, tbl[i].er, tbl[i].epc, tbl[i].einst, tbl[i].ecnt);
         @(negedge clk);
      end

      // Streaming: continuous push and pop.
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, 32'(4 * k), 1'b0, 1'b1);
         ev  = (k != 0) || BYP;
         ec  = (k == 0 || BYP) ? 3'd0 : 3'd1;
         epc = BYP ? 32'(4 * k) : (k == 0 ? 32'h0 : 32'(4 * (k - 1)));
         #1 chk_all($sformatf("stream%0d", k), ev, 1'b1, epc, ev ? inst_of(epc) : NOP, ec);
         @(negedge clk);
      end
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      epc = BYP ? 32'h0 : 32'd28;
      #1 chk_all("stream_tail", !BYP, 1'b1, epc, BYP ? NOP : inst_of(epc), BYP ? 3'd0 : 3'd1);
      @(negedge clk);

      // Wrap-around: hold occupancy at 3 across 10 push/pop pairs.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h200 + 32'(4 * i), 1'b0, 1'b0);
         ev  = (i != 0) || BYP;
         epc = ev ? 32'h200 : 32'h0;
         #1 chk_all($sformatf("wpre%0d", i), ev, 1'b1, epc, ev ? inst_of(epc) : NOP, 3'(i));
         @(negedge clk);
      end
      for (int k = 0; k < 10; k++) begin
         drive(1'b1, 32'h20C + 32'(4 * k), 1'b0, 1'b1);
         epc = 32'h200 + 32'(4 * k);
         #1 chk_all($sformatf("wrap%0d", k), 1'b1, 1'b1, epc, inst_of(epc), 3'd3);
         @(negedge clk);
      end
      for (int j = 0; j < 3; j++) begin
         drive(1'b0, 32'h0, 1'b0, 1'b1);
         epc = 32'h228 + 32'(4 * j);
         #1 chk_all($sformatf("wdrain%0d", j), 1'b1, 1'b1, epc, inst_of(epc), 3'(3 - j));
         @(negedge clk);
      end

      // Flush at count=3 with a concurrent push: the push is dropped.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h500 + 32'(4 * i), 1'b0, 1'b0);
         @(negedge clk);
      end
      drive(1'b1, 32'h20, 1'b1, 1'b0);
      #1 chk("flush_pre.count", 32'(count), 32'd3);
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      #1 chk_all("flush_post", 1'b0, 1'b1, 32'h0, NOP, 3'd0);
      @(negedge clk);
      drive(1'b1, 32'h100, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      #1 chk_all("after_flush", 1'b1, 1'b1, 32'h100, inst_of(32'h100), 3'd1);
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      @(negedge clk);

      // Asynchronous reset between clock edges.
      drive(1'b1, 32'h600, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b1, 32'h604, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      #1 chk("areset_pre.count", 32'(count), 32'd2);
      #2 reset_n = 1'b0;
      #1 chk_all("areset", 1'b0, 1'b1, 32'h0, NOP, 3'd0);
      @(negedge clk);
      reset_n = 1'b1;
      drive(1'b1, 32'h700, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      #1 chk_all("post_reset_push", 1'b1, 1'b1, 32'h700, inst_of(32'h700), 3'd1);
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      @(negedge clk);

      // Randomized traffic against a queue model (queue starts empty here).
      model_q.delete();
      for (int c = 0; c < 400; c++) begin
         logic        v, ordy, fl, byp, er;
         logic [31:0] pc, einst;
         int          n;
         v    = ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 2) != 0);
         fl   = ($urandom_range(0, 19) == 0);
         pc   = $urandom() & 32'hFFFF_FFFC;
         drive(v, pc, fl, ordy);
         n   = model_q.size();
         byp = BYP && (n == 0) && v && !fl;
         ev  = (n != 0) || byp;
         er  = (n != 4);
         if (n != 0) begin
            epc   = model_q[0].pc;
            einst = model_q[0].inst;
         end else if (byp) begin
            epc   = pc;
            einst = inst_of(pc);
         end else begin
            epc   = 32'h0;
            einst = NOP;
         end
         #1 chk_all($sformatf("rnd%0d", c), ev, er, epc, einst, 3'(n));
         if (fl) model_q.delete();
         else if (!(byp && ordy)) begin
            if (ordy && n != 0) void'(model_q.pop_front());
            if (v && er) model_q.push_back('{pc, inst_of(pc)});
         end
         @(negedge clk);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_fetch_queue
